// File: rtl/mac_sequencer.sv
// mac_sequencer: streams len weight/input pairs from two RAMs into a MAC core and captures the dot-product.
// Define MAC_SEQ_ABORT_EN to add the abort input that cancels a running evaluation.
module mac_sequencer #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int LEN_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
`ifdef MAC_SEQ_ABORT_EN
   input  logic              abort,
`endif
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic [ADDR_W-1:0] w_base,
   input  logic [ADDR_W-1:0] x_base,
   output logic              busy,
   output logic [DATA_W-1:0] result,
   output logic              result_valid,
   output logic              w_rd_en,
   output logic              x_rd_en,
   output logic [ADDR_W-1:0] w_addr,
   output logic [ADDR_W-1:0] x_addr,
   input  logic [DATA_W-1:0] w_rdata,
   input  logic [DATA_W-1:0] x_rdata,
   output logic [DATA_W-1:0] mac_weight,
   output logic [DATA_W-1:0] mac_in,
   output logic              mac_forget,
   output logic              mac_oe,
   output logic              mac_reset,
   input  logic [DATA_W-1:0] mac_out
);
   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, CAPTURE} state_t;
   state_t state, state_nx;
   logic [LEN_W-1:0] len_q, cnt;
   logic [ADDR_W-1:0] wb, xb;
   logic rd_q, first_q, forget_q, abort_q, kill, accept, capture;
`ifdef MAC_SEQ_ABORT_EN
   assign kill = abort && state != IDLE;
`else
   assign kill = 1'b0;
`endif
   assign accept = start && state == IDLE;
   assign capture = state == CAPTURE && !kill;
   always_ff @(posedge clk)
      state <= reset ? IDLE : state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept && len != '0) state_nx = FETCH;
         FETCH:   if (cnt + LEN_W'(1) == len_q) state_nx = DRAIN;
         DRAIN:   if (cnt == LEN_W'(1)) state_nx = CAPTURE;
         default: state_nx = IDLE;
      endcase
      if (kill) state_nx = IDLE;
   end
   // cnt restarts on every state change: pair index in FETCH, drain cycle in DRAIN
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
         len_q <= '0;
         wb <= '0;
         xb <= '0;
         rd_q <= 1'b0;
         first_q <= 1'b0;
         forget_q <= 1'b0;
         abort_q <= 1'b0;
         result <= '0;
         result_valid <= 1'b0;
      end else begin
         cnt <= (state_nx != state) ? '0 : cnt + LEN_W'(1);
         if (accept) begin
            len_q <= len;
            wb <= w_base;
            xb <= x_base;
         end
         rd_q <= w_rd_en && !kill;
         first_q <= w_rd_en && cnt == '0 && !kill;
         forget_q <= first_q && !kill;
         abort_q <= kill;
         result_valid <= capture || (accept && len == '0);
         if (capture) result <= mac_out;
         else if (accept && len == '0) result <= '0;
      end
   end
   assign busy = state != IDLE;
   assign w_rd_en = state == FETCH;
   assign x_rd_en = w_rd_en;
   assign w_addr = w_rd_en ? wb + ADDR_W'(cnt) : '0;
   assign x_addr = x_rd_en ? xb + ADDR_W'(cnt) : '0;
   assign mac_weight = rd_q ? w_rdata : '0;
   assign mac_in = rd_q ? x_rdata : '0;
   assign mac_forget = forget_q;
   assign mac_oe = state == CAPTURE;
   assign mac_reset = reset || abort_q;
endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: directed bench with RAM and MAC models around mac_sequencer.
module tb_mac_sequencer;
   logic clk = 1'b0, reset = 1'b1, start = 1'b0;
   logic [7:0] len = '0, w_base = '0, x_base = '0;
   logic busy, result_valid, w_rd_en, x_rd_en, mac_forget, mac_oe, mac_reset;
   logic [7:0] result, w_addr, x_addr, w_rdata, x_rdata, mac_weight, mac_in;
   wire [7:0] mac_out;
   logic [7:0] wmem [256], xmem [256];
   logic [7:0] wr, ir, acc;
   int checks = 0, failures = 0;
`ifdef MAC_SEQ_ABORT_EN
   logic abort = 1'b0;
`endif
   localparam logic [47:0] T1 = {6'b111000, 6'b111000, 6'b111100, 6'b100000, 6'b100000, 6'b100010, 6'b000001, 6'b000000};
   localparam logic [47:0] T2 = {6'b111000, 6'b111000, 6'b100100, 6'b100000, 6'b100010, 6'b000001, 6'b000000, 6'b000000};
   localparam logic [47:0] T3 = {6'b000001, 6'b000000, 36'd0};
   localparam logic [47:0] T4 = {6'b111000, 6'b100000, 6'b100100, 6'b100010, 6'b000001, 6'b000000, 6'b000000, 6'b000000};
   localparam logic [47:0] T5 = {6'b111000, 6'b111000, 36'd0};
   localparam logic [47:0] T0 = 48'd0;

   mac_sequencer dut (
      .clk(clk), .reset(reset),
`ifdef MAC_SEQ_ABORT_EN
      .abort(abort),
`endif
      .start(start), .len(len), .w_base(w_base), .x_base(x_base),
      .busy(busy), .result(result), .result_valid(result_valid),
      .w_rd_en(w_rd_en), .x_rd_en(x_rd_en), .w_addr(w_addr), .x_addr(x_addr),
      .w_rdata(w_rdata), .x_rdata(x_rdata), .mac_weight(mac_weight), .mac_in(mac_in),
      .mac_forget(mac_forget), .mac_oe(mac_oe), .mac_reset(mac_reset), .mac_out(mac_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (w_rd_en) w_rdata <= wmem[w_addr];
      if (x_rd_en) x_rdata <= xmem[x_addr];
   end

   // MAC core model: operands registered at one edge, accumulated at the next
   always @(posedge clk) begin
      if (mac_reset) begin
         wr <= '0;
         ir <= '0;
         acc <= '0;
      end else begin
         wr <= mac_weight;
         ir <= mac_in;
         acc <= (mac_forget ? 8'd0 : acc) + wr * ir;
      end
   end
   assign mac_out = mac_oe ? acc : 8'bz;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic go(input logic [7:0] l, input logic [7:0] wb, input logic [7:0] xb);
      start = 1'b1;
      len = l;
      w_base = wb;
      x_base = xb;
   endtask

   // step k of tbl is {busy, w_rd_en, x_rd_en, mac_forget, mac_oe, result_valid} in cycle t+1+k
   task automatic trace(input string tag, input int n, input logic [47:0] tbl,
                        input logic [7:0] wb, input logic [7:0] xb, input int poke);
      logic prev;
      prev = 1'b0;
      for (int k = 0; k < n; k++) begin
         logic [5:0] e;
         @(negedge clk);
         start = (k == poke);
         if (k == poke) len = '0;
         e = tbl[47-6*k -: 6];
         chk({tag, "_ctl"}, {busy, w_rd_en, x_rd_en, mac_forget, mac_oe, result_valid}, e);
         if (e[4]) chk({tag, "_addr"}, {w_addr, x_addr}, {wb + 8'(k), xb + 8'(k)});
         if (!prev) chk({tag, "_gate"}, {mac_weight, mac_in}, 0);
         prev = e[4];
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         wmem[i] = '0;
         xmem[i] = '0;
      end
      wmem[254] = 2;  wmem[255] = 3;  wmem[0] = 4;
      xmem[20] = 5;   xmem[21] = 6;   xmem[22] = 7;
      wmem[30] = 16;  wmem[31] = 16;  xmem[40] = 16;  xmem[41] = 1;
      wmem[50] = 10;  xmem[50] = 10;  wmem[51] = 9;   xmem[51] = 9;
      wmem[60] = 3;   xmem[60] = 3;
      for (int i = 100; i < 105; i++) begin
         wmem[i] = 8'(i);
         xmem[i] = 1;
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_state", {busy, result_valid, w_rd_en, mac_forget, mac_oe, mac_reset}, 0);
      chk("rst_result", result, 0);
      go(3, 254, 20);
      trace("t1", 8, T1, 254, 20, -1);
      chk("t1_result", result, 56);
      go(2, 30, 40);
      trace("t2", 6, T2, 30, 40, 1);
      chk("t2_result", result, 16);
      go(0, 0, 0);
      trace("t3", 2, T3, 0, 0, -1);
      chk("t3_result", result, 0);
      go(1, 50, 50);
      trace("t4a", 5, T4, 50, 50, -1);
      chk("t4a_result", result, 100);
      go(1, 51, 51);
      trace("t4b", 5, T4, 51, 51, -1);
      chk("t4b_result", result, 81);
      go(5, 100, 100);
      trace("t5", 2, T5, 100, 100, -1);
      reset = 1'b1;
      #1 chk("t5_mac_reset", mac_reset, 1);
      @(negedge clk);
      chk("t5_after_rst", {busy, w_rd_en, x_rd_en, result_valid, mac_forget, mac_oe}, 0);
      reset = 1'b0;
      trace("t5_idle", 2, T0, 0, 0, -1);
      chk("t5_result_cleared", result, 0);
      go(1, 60, 60);
      trace("t6", 5, T4, 60, 60, -1);
      chk("t6_result", result, 9);
`ifdef MAC_SEQ_ABORT_EN
      go(1, 50, 50);
      trace("ab", 2, {6'b111000, 6'b100000, 36'd0}, 50, 50, -1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("ab_cut", {busy, mac_reset, result_valid, mac_forget, mac_oe}, 5'b01000);
      @(negedge clk);
      chk("ab_after", {busy, mac_reset, result_valid, mac_forget, mac_oe}, 0);
      chk("ab_result", result, 9);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
